// File: rtl/ysyx_24100005_pkg.sv
// rtl/ysyx_24100005_pkg.sv - shared state encoding and instruction constants for the core controller
package ysyx_24100005_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_I,
        EXEC,
        MEM,
        WAIT_D,
        HALT,
        ERR
    } state_t;

    localparam logic [6:0]  LOAD   = 7'b000_0011;
    localparam logic [6:0]  STORE  = 7'b010_0011;
    localparam logic [6:0]  SYSTEM = 7'b111_0011;
    localparam logic [31:0] EBREAK = 32'h0010_0073;

    function automatic logic is_ebreak(input logic [31:0] i);
        return (i[6:0] == SYSTEM) && (i[31:7] == EBREAK[31:7]);
    endfunction

    function automatic logic is_mem_op(input logic [31:0] i);
        return (i[6:0] == LOAD) || (i[6:0] == STORE);
    endfunction

endpackage

// File: rtl/ysyx_24100005_wdog.sv
// rtl/ysyx_24100005_wdog.sv - wait timer that flags the last permitted cycle of a memory wait
module ysyx_24100005_wdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int             CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // count holds the number of completed waiting cycles; expired marks the TIMEOUT-th one
    assign expired = en && (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_24100005_core_ctrl.sv
// rtl/ysyx_24100005_core_ctrl.sv - multi-cycle fetch/execute/memory sequencer with halt, timeout and perf counters
module ysyx_24100005_core_ctrl
    import ysyx_24100005_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] inst,
    input  logic        rf_wen_req,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    input  logic        dmem_rsp_valid,
    output logic        pc_wen,
    output logic        rf_wen,
    output logic        ebreak_ev,
    output logic        halted,
    output logic        err,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
);

    state_t      state, state_nxt;
    logic [31:0] inst_q;
    logic [63:0] cycle_q, instret_q;
    logic        ireq, dreq, pw, rw, eb, cap;
    logic        wd_clr, wd_en, wd_expired;

    assign wd_clr = (state == FETCH && imem_req_ready) || (state == MEM && dmem_req_ready);
    assign wd_en  = (state == WAIT_I) || (state == WAIT_D);

    ysyx_24100005_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    always_comb begin
        state_nxt = state;
        ireq      = 1'b0;
        dreq      = 1'b0;
        pw        = 1'b0;
        rw        = 1'b0;
        eb        = 1'b0;
        cap       = 1'b0;
        case (state)
            IDLE:   state_nxt = FETCH;
            FETCH: begin
                ireq = 1'b1;
                if (imem_req_ready) state_nxt = WAIT_I;
            end
            // a response on the final timer cycle still wins over the timeout
            WAIT_I: begin
                if (imem_rsp_valid) begin
                    cap       = 1'b1;
                    state_nxt = EXEC;
                end else if (wd_expired) begin
                    state_nxt = ERR;
                end
            end
            EXEC: begin
                if (is_ebreak(inst_q)) begin
                    eb        = 1'b1;
                    state_nxt = HALT;
                end else if (is_mem_op(inst_q)) begin
                    state_nxt = MEM;
                end else begin
                    pw        = 1'b1;
                    rw        = rf_wen_req;
                    state_nxt = FETCH;
                end
            end
            MEM: begin
                dreq = 1'b1;
                if (dmem_req_ready) state_nxt = WAIT_D;
            end
            WAIT_D: begin
                if (dmem_rsp_valid) begin
                    pw        = 1'b1;
                    rw        = rf_wen_req && (inst_q[6:0] == LOAD);
                    state_nxt = FETCH;
                end else if (wd_expired) begin
                    state_nxt = ERR;
                end
            end
            HALT:    state_nxt = HALT;
            ERR:     state_nxt = ERR;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            inst_q    <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            state <= state_nxt;
            if (cap) inst_q <= imem_rsp_data;
            if (state != HALT && state != ERR) cycle_q <= cycle_q + 64'd1;
            if (pw || eb) instret_q <= instret_q + 64'd1;
        end
    end

    // reset is synchronous, so outputs are masked while it is held to keep them quiet before the edge
    assign imem_req_valid = !rst && ireq;
    assign imem_addr      = (!rst && ireq) ? pc : 32'h0;
    assign dmem_req_valid = !rst && dreq;
    assign pc_wen         = !rst && pw;
    assign rf_wen         = !rst && rw;
    assign ebreak_ev      = !rst && eb;
    assign halted         = !rst && (state == HALT);
    assign err            = !rst && (state == ERR);
    assign inst           = rst ? 32'h0 : inst_q;
    assign cycle_cnt      = rst ? 64'h0 : cycle_q;
    assign instret_cnt    = rst ? 64'h0 : instret_q;

endmodule

// File: tb/tb_ysyx_24100005_core_ctrl.sv
// tb/tb_ysyx_24100005_core_ctrl.sv - directed bench with a per-cycle expectation model for the core controller
module tb_ysyx_24100005_core_ctrl;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] ADDI  = 32'h0050_0093;
    localparam logic [31:0] ADD   = 32'h0020_81b3;
    localparam logic [31:0] LW    = 32'h0000_2083;
    localparam logic [31:0] SW    = 32'h0010_2023;
    localparam logic [31:0] EBRK  = 32'h0010_0073;

    localparam logic [5:0] I_NONE = 6'b000000;
    localparam logic [5:0] I_RST  = 6'b100000;
    localparam logic [5:0] I_IRDY = 6'b010000;
    localparam logic [5:0] I_IRSP = 6'b001000;
    localparam logic [5:0] I_DRDY = 6'b000100;
    localparam logic [5:0] I_DRSP = 6'b000010;
    localparam logic [5:0] I_RQ   = 6'b000001;

    localparam logic [6:0] X_NONE = 7'b0000000;
    localparam logic [6:0] X_IV   = 7'b1000000;
    localparam logic [6:0] X_DV   = 7'b0100000;
    localparam logic [6:0] X_PW   = 7'b0010000;
    localparam logic [6:0] X_RW   = 7'b0001000;
    localparam logic [6:0] X_EB   = 7'b0000100;
    localparam logic [6:0] X_CAP  = 7'b0000010;
    localparam logic [6:0] X_ERR  = 7'b0000001;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] pc = BASE;
    logic        imem_req_valid, imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic [31:0] inst;
    logic        rf_wen_req = 1'b0;
    logic        dmem_req_valid, dmem_req_ready = 1'b0, dmem_rsp_valid = 1'b0;
    logic        pc_wen, rf_wen, ebreak_ev, halted, err;
    logic [63:0] cycle_cnt, instret_cnt;

    logic        e_iv = 0, e_dv = 0, e_pw = 0, e_rw = 0, e_eb = 0, e_cap = 0, e_err = 0;
    logic [63:0] m_cycle = 0, m_instret = 0;
    logic [31:0] m_inst = 0;
    logic        m_halted = 0, m_err = 0;
    logic        chk_on = 0;
    int          n_checks = 0, n_err = 0;

    always #5 clk = ~clk;

    ysyx_24100005_core_ctrl #(.TIMEOUT(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst           (inst),
        .rf_wen_req     (rf_wen_req),
        .dmem_req_valid (dmem_req_valid),
        .dmem_req_ready (dmem_req_ready),
        .dmem_rsp_valid (dmem_rsp_valid),
        .pc_wen         (pc_wen),
        .rf_wen         (rf_wen),
        .ebreak_ev      (ebreak_ev),
        .halted         (halted),
        .err            (err),
        .cycle_cnt      (cycle_cnt),
        .instret_cnt    (instret_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("imem_req_valid", 64'(imem_req_valid), 64'(e_iv));
            chk("imem_addr", 64'(imem_addr), 64'(e_iv ? pc : 32'h0));
            chk("dmem_req_valid", 64'(dmem_req_valid), 64'(e_dv));
            chk("pc_wen", 64'(pc_wen), 64'(e_pw));
            chk("rf_wen", 64'(rf_wen), 64'(e_rw));
            chk("ebreak_ev", 64'(ebreak_ev), 64'(e_eb));
            chk("halted", 64'(halted), 64'(!rst && m_halted));
            chk("err", 64'(err), 64'(!rst && m_err));
            chk("inst", 64'(inst), 64'(rst ? 32'h0 : m_inst));
            chk("cycle_cnt", cycle_cnt, rst ? 64'h0 : m_cycle);
            chk("instret_cnt", instret_cnt, rst ? 64'h0 : m_instret);
        end
    end

    // one clock: apply inputs and this cycle's expected strobes, then advance the model
    task automatic cyc(input logic [5:0] iv, input logic [31:0] id, input logic [6:0] ex);
        rst            = iv[5];
        imem_req_ready = iv[4];
        imem_rsp_valid = iv[3];
        imem_rsp_data  = id;
        dmem_req_ready = iv[2];
        dmem_rsp_valid = iv[1];
        rf_wen_req     = iv[0];
        {e_iv, e_dv, e_pw, e_rw, e_eb, e_cap, e_err} = ex;
        @(posedge clk);
        #1;
        if (rst) begin
            m_cycle = 0; m_instret = 0; m_inst = 0; m_halted = 0; m_err = 0; pc = BASE;
        end else begin
            if (!m_halted && !m_err) m_cycle = m_cycle + 64'd1;
            if (e_pw || e_eb) m_instret = m_instret + 64'd1;
            if (e_eb) m_halted = 1'b1;
            if (e_err) m_err = 1'b1;
            if (e_cap) m_inst = id;
            if (e_pw) pc = pc + 32'd4;
        end
    endtask

    task automatic do_reset();
        cyc(I_RST, 32'h0, X_NONE);
        cyc(I_RST, 32'h0, X_NONE);
        cyc(I_NONE, 32'h0, X_NONE);
    endtask

    // full instruction: fetch stall, imem wait, execute, then optional data stall and wait
    task automatic run_inst(input logic [31:0] ins, input logic rq, input int rdly,
                            input int iw, input int ddly, input int dw);
        logic [5:0] r;
        logic       mem, ld;
        r   = rq ? I_RQ : I_NONE;
        mem = (ins[6:0] == 7'b000_0011) || (ins[6:0] == 7'b010_0011);
        ld  = (ins[6:0] == 7'b000_0011);
        for (int k = 0; k < rdly; k++) cyc(r | I_IRSP, 32'hdead_beef, X_IV);
        cyc(r | I_IRDY, 32'h0, X_IV);
        for (int k = 0; k < iw; k++) cyc(r, 32'h0, X_NONE);
        cyc(r | I_IRSP, ins, X_CAP);
        if (ins == EBRK) begin
            cyc(r, 32'h0, X_EB);
        end else if (!mem) begin
            cyc(r, 32'h0, X_PW | (rq ? X_RW : X_NONE));
        end else begin
            cyc(r, 32'h0, X_NONE);
            for (int k = 0; k < ddly; k++) cyc(r, 32'h0, X_DV);
            cyc(r | I_DRDY, 32'h0, X_DV);
            for (int k = 0; k < dw; k++) cyc(r, 32'h0, X_NONE);
            cyc(r | I_DRSP, 32'h0, X_PW | ((rq && ld) ? X_RW : X_NONE));
        end
    endtask

    initial begin
        cyc(I_RST, 32'h0, X_NONE);
        chk_on = 1'b1;

        do_reset();
        chk("pin_fetch_addr", 64'(imem_addr), 64'(32'h8000_0000));
        run_inst(ADDI, 1'b1, 0, 0, 0, 0);
        chk("pin_addi_instret", instret_cnt, 64'd1);
        chk("pin_addi_cycle", cycle_cnt, 64'd4);
        chk("pin_addi_inst", 64'(inst), 64'(32'h0050_0093));

        do_reset();
        run_inst(ADDI, 1'b1, 10, 0, 0, 0);
        chk("pin_stall_cycle", cycle_cnt, 64'd14);
        chk("pin_stall_instret", instret_cnt, 64'd1);

        do_reset();
        run_inst(LW, 1'b1, 0, 0, 2, 3);
        run_inst(SW, 1'b1, 0, 0, 0, 1);
        run_inst(ADD, 1'b0, 0, 0, 0, 0);
        run_inst(EBRK, 1'b1, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) cyc(I_IRDY | I_IRSP | I_DRDY | I_DRSP | I_RQ, ADDI, X_NONE);
        chk("pin_halt_flag", 64'(halted), 64'd1);
        chk("pin_halt_instret", instret_cnt, 64'd4);
        chk("pin_halt_cycle", cycle_cnt, 64'd23);

        do_reset();
        cyc(I_IRDY, 32'h0, X_IV);
        for (int k = 1; k <= 8; k++) cyc(I_NONE, 32'h0, (k == 8) ? X_ERR : X_NONE);
        for (int k = 0; k < 3; k++) cyc(I_IRDY | I_IRSP | I_DRDY | I_DRSP | I_RQ, ADDI, X_NONE);
        chk("pin_timeout_err", 64'(err), 64'd1);
        chk("pin_timeout_cycle", cycle_cnt, 64'd10);

        do_reset();
        run_inst(ADDI, 1'b1, 0, 7, 0, 0);
        chk("pin_late_rsp_err", 64'(err), 64'd0);
        chk("pin_late_rsp_instret", instret_cnt, 64'd1);

        do_reset();
        cyc(I_IRDY | I_RQ, 32'h0, X_IV);
        cyc(I_IRSP | I_RQ, LW, X_CAP);
        cyc(I_RQ, 32'h0, X_NONE);
        cyc(I_DRDY | I_RQ, 32'h0, X_DV);
        cyc(I_RQ, 32'h0, X_NONE);
        cyc(I_RST | I_DRSP | I_RQ, 32'h0, X_NONE);
        chk("pin_rst_cycle", cycle_cnt, 64'd0);
        chk("pin_rst_inst", 64'(inst), 64'd0);
        cyc(I_DRSP | I_RQ, 32'h0, X_NONE);
        run_inst(ADDI, 1'b1, 0, 0, 0, 0);
        chk("pin_rst_restart_instret", instret_cnt, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
